// File: rtl/dlsc_pcie_s6_outbound_read_sched_if.sv
// Command-side and header-side handshake bundle for the outbound read scheduler.
// master = scheduler, slave = requesters plus read allocator.
interface dlsc_pcie_s6_outbound_read_sched_if #(
    parameter int ADDR = 32,
    parameter int LEN  = 16,
    parameter int REQS = 2,
    parameter int SRCB = (REQS > 1) ? $clog2(REQS) : 1
);
    logic [REQS-1:0]          cmd_ready;
    logic [REQS-1:0]          cmd_valid;
    logic [REQS*(ADDR-2)-1:0] cmd_addr;
    logic [REQS*LEN-1:0]      cmd_len;
    logic [REQS-1:0]          cmd_done;
    logic                     busy;

    logic                     tlp_h_ready;
    logic                     tlp_h_valid;
    logic [ADDR-3:0]          tlp_h_addr;
    logic [9:0]               tlp_h_len;
    logic [SRCB-1:0]          tlp_h_src;
    logic                     tlp_h_last;

    modport master (
        output cmd_ready, cmd_done, busy,
        output tlp_h_valid, tlp_h_addr, tlp_h_len, tlp_h_src, tlp_h_last,
        input  cmd_valid, cmd_addr, cmd_len, tlp_h_ready
    );

    modport slave (
        input  cmd_ready, cmd_done, busy,
        input  tlp_h_valid, tlp_h_addr, tlp_h_len, tlp_h_src, tlp_h_last,
        output cmd_valid, cmd_addr, cmd_len, tlp_h_ready
    );
endinterface

// File: rtl/dlsc_pcie_s6_outbound_read_sched.sv
// Round-robin read scheduler: grants one requester command, splits it into MRRS-aligned headers.
// Latency: accept -> first header 2 cycles; one bubble between headers; headers held while not ready.
module dlsc_pcie_s6_outbound_read_sched #(
    parameter int ADDR = 32,
    parameter int LEN  = 16,
    parameter int REQS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dma_en,
    input  logic [2:0] max_read_request,
    dlsc_pcie_s6_outbound_read_sched_if.master bus
);
    localparam int SRCB = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int AW   = ADDR - 2;
    localparam int NW   = (LEN > 11) ? LEN : 11;

    typedef enum logic [1:0] {IDLE, SPLIT, ISSUE} state_t;

    state_t            state, state_nxt;
    logic [SRCB-1:0]   ptr;
    logic [SRCB-1:0]   grant;
    logic              grant_vld;
    logic [2*REQS-1:0] vld_rot;
    logic [REQS-1:0]   cmd_rdy;
    logic              accept;
    logic [AW-1:0]     addr_sel;
    logic [LEN-1:0]    len_sel;

    logic [AW-1:0]     addr_q;
    logic [LEN-1:0]    rem_q;
    logic [SRCB-1:0]   src_q;
    logic [10:0]       n_q;

    logic [10:0]       mrrs_dw;
    logic [9:0]        offs;
    logic [10:0]       room;
    logic [10:0]       n;

    logic              h_vld;
    logic [AW-1:0]     h_addr;
    logic [9:0]        h_len;
    logic [SRCB-1:0]   h_src;
    logic              h_last;
    logic [REQS-1:0]   done_q;
    logic              busy_q;

    // Rotate valids so bit 0 is the current highest-priority requester.
    always_comb begin
        vld_rot   = {bus.cmd_valid, bus.cmd_valid} >> ptr;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            if (!grant_vld && vld_rot[k]) begin
                grant_vld = 1'b1;
                grant     = SRCB'((int'(ptr) + k) % REQS);
            end
        end
    end

    assign addr_sel = bus.cmd_addr[int'(grant)*AW +: AW];
    assign len_sel  = bus.cmd_len[int'(grant)*LEN +: LEN];

    // Split size: never run past the next MRRS-aligned boundary.
    always_comb begin
        mrrs_dw = (max_read_request > 3'd5) ? 11'd32 : (11'd32 << max_read_request);
        offs    = addr_q[9:0] & (mrrs_dw[9:0] - 10'd1);
        room    = mrrs_dw - {1'b0, offs};
        n       = (NW'(rem_q) < NW'(room)) ? 11'(rem_q) : room;
    end

    always_comb begin
        state_nxt = state;
        cmd_rdy   = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (dma_en && grant_vld) begin
                    accept         = 1'b1;
                    cmd_rdy[grant] = 1'b1;
                    if (len_sel != '0) state_nxt = SPLIT;
                end
            end
            SPLIT: begin
                if (dma_en) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (bus.tlp_h_ready) state_nxt = h_last ? IDLE : SPLIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            src_q  <= '0;
            n_q    <= '0;
            h_vld  <= 1'b0;
            h_addr <= '0;
            h_len  <= '0;
            h_src  <= '0;
            h_last <= 1'b0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            done_q <= '0;
            if (accept) begin
                addr_q <= addr_sel;
                rem_q  <= len_sel;
                src_q  <= grant;
                ptr    <= (grant == SRCB'(REQS - 1)) ? '0 : grant + 1'b1;
                if (len_sel == '0) done_q <= REQS'(1) << grant;
                else               busy_q <= 1'b1;
            end
            if (state == SPLIT && dma_en) begin
                h_vld  <= 1'b1;
                h_addr <= addr_q;
                h_len  <= n[9:0];
                h_src  <= src_q;
                h_last <= (NW'(rem_q) == NW'(n));
                n_q    <= n;
            end
            if (state == ISSUE && bus.tlp_h_ready) begin
                h_vld  <= 1'b0;
                addr_q <= addr_q + AW'(n_q);
                rem_q  <= rem_q - LEN'(n_q);
                if (h_last) begin
                    done_q <= REQS'(1) << h_src;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_rdy;
    assign bus.cmd_done    = done_q;
    assign bus.busy        = busy_q;
    assign bus.tlp_h_valid = h_vld;
    assign bus.tlp_h_addr  = h_addr;
    assign bus.tlp_h_len   = h_len;
    assign bus.tlp_h_src   = h_src;
    assign bus.tlp_h_last  = h_last;
endmodule
